// File: rtl/sfifo.sv
// sfifo: single-clock synchronous FIFO with selectable first-word-fall-through
// (FWFT) or registered-read output, almost-full/almost-empty thresholds,
// synchronous flush, sticky error flags and an exact occupancy count.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   reset      synchronous active-high reset (priority over everything)
//   flush      synchronous discard of all contents
//   we, d      write request and write data
//   wfull      count == DEPTH
//   wafull     count >= AFN
//   re         read request / pop
//   q          read data (FWFT: head entry; registered: data of last pop)
//   rvalid     FWFT: ~rempty; registered: one-cycle pulse per accepted read
//   rempty     count == 0
//   raempty    count <= AEN
//   count      occupancy, 0..DEPTH
//   overflow   sticky, write attempted while full
//   underflow  sticky, read attempted while empty
module sfifo #(
   parameter int AW   = 4,
   parameter int DW   = 32,
   parameter int AFN  = (2 ** AW) - 2,
   parameter int AEN  = 1,
   parameter int FWFT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          we,
   input  logic [DW-1:0] d,
   output logic          wfull,
   output logic          wafull,
   input  logic          re,
   output logic [DW-1:0] q,
   output logic          rvalid,
   output logic          rempty,
   output logic          raempty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AFN_C   = (AW + 1)'(AFN);
   localparam logic [AW:0] AEN_C   = (AW + 1)'(AEN);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] rptr_inc;
   logic [AW:0]   count_nxt;
   logic          wt;
   logic          rd;

   // Flags come from the count register only, so no input reaches an output
   // combinationally.
   assign wfull   = (count == DEPTH_C);
   assign wafull  = (count >= AFN_C);
   assign rempty  = (count == '0);
   assign raempty = (count <= AEN_C);

   // Acceptance uses the start-of-cycle flags: a simultaneous read does not
   // make room for a write to a full FIFO, and vice versa for empty.
   assign wt       = we & ~wfull;
   assign rd       = re & ~rempty;
   assign rptr_inc = rptr + 1'b1;

   always_comb begin
      count_nxt = count;
      if (wt && !rd)
         count_nxt = count + 1'b1;
      else if (rd && !wt)
         count_nxt = count - 1'b1;
   end

   // Storage is not reset; contents behind the pointers are never observed.
   always_ff @(posedge clk) begin
      if (!reset && !flush && wt)
         mem[wptr] <= d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         q         <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         // q intentionally holds; only the bookkeeping is discarded.
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wt)
            wptr <= wptr + 1'b1;
         if (rd)
            rptr <= rptr_inc;
         count     <= count_nxt;
         overflow  <= overflow  | (we & wfull);
         underflow <= underflow | (re & rempty);
         if (FWFT != 0) begin
            // q is a registered copy of the head entry. After a pop the new
            // head is the next slot, unless that slot is being written this
            // very cycle (FIFO held one entry), in which case it is d.
            rvalid <= (count_nxt != '0);
            if (rd) begin
               if (wt && (wptr == rptr_inc))
                  q <= d;
               else
                  q <= mem[rptr_inc];
            end else if (wt && rempty) begin
               q <= d;
            end
         end else begin
            rvalid <= rd;
            if (rd)
               q <= mem[rptr];
         end
      end
   end

endmodule

// File: tb/tb_sfifo.sv
// tb_sfifo: directed self-checking bench for sfifo. Two instances with AW=2,
// DW=8 share one clock: u_fw in FWFT mode and u_rg in registered-read mode.
module tb_sfifo;

   logic       clk = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic       reset_f, flush_f, we_f, re_f;
   logic [7:0] d_f, q_f;
   logic       wfull_f, wafull_f, rvalid_f, rempty_f, raempty_f, overflow_f, underflow_f;
   logic [2:0] count_f;

   logic       reset_r, flush_r, we_r, re_r;
   logic [7:0] d_r, q_r;
   logic       wfull_r, wafull_r, rvalid_r, rempty_r, raempty_r, overflow_r, underflow_r;
   logic [2:0] count_r;

   always #5 clk = ~clk;

   sfifo #(.AW(2), .DW(8), .FWFT(1)) u_fw (
      .clk(clk), .reset(reset_f), .flush(flush_f), .we(we_f), .d(d_f),
      .wfull(wfull_f), .wafull(wafull_f), .re(re_f), .q(q_f), .rvalid(rvalid_f),
      .rempty(rempty_f), .raempty(raempty_f), .count(count_f),
      .overflow(overflow_f), .underflow(underflow_f)
   );

   sfifo #(.AW(2), .DW(8), .FWFT(0)) u_rg (
      .clk(clk), .reset(reset_r), .flush(flush_r), .we(we_r), .d(d_r),
      .wfull(wfull_r), .wafull(wafull_r), .re(re_r), .q(q_r), .rvalid(rvalid_r),
      .rempty(rempty_r), .raempty(raempty_r), .count(count_r),
      .overflow(overflow_r), .underflow(underflow_r)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // flag vector order: wfull wafull rempty raempty rvalid overflow underflow
   task automatic test_reset();
      reset_f = 1'b1; reset_r = 1'b1;
      tick(); tick();
      checks++;
      if ({wfull_f, wafull_f, rempty_f, raempty_f, rvalid_f, overflow_f, underflow_f} !== 7'b0011000) begin
         errors++;
         $display("FAIL reset_flags_f: got %b want 0011000",
                  {wfull_f, wafull_f, rempty_f, raempty_f, rvalid_f, overflow_f, underflow_f});
      end
      checks++;
      if (count_f !== 3'd0 || q_f !== 8'h00) begin
         errors++;
         $display("FAIL reset_cnt_q_f: got count=%0d q=%0h want 0/0", count_f, q_f);
      end
      checks++;
      if ({wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r} !== 7'b0011000) begin
         errors++;
         $display("FAIL reset_flags_r: got %b want 0011000",
                  {wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r});
      end
      checks++;
      if (count_r !== 3'd0 || q_r !== 8'h00) begin
         errors++;
         $display("FAIL reset_cnt_q_r: got count=%0d q=%0h want 0/0", count_r, q_r);
      end
      reset_f = 1'b0; reset_r = 1'b0;
   endtask

   task automatic test_fill();
      logic [7:0] vals [4];
      vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int i = 0; i < 4; i++) begin
         we_f = 1'b1; d_f = vals[i];
         tick();
         checks++;
         if (count_f !== 3'(i + 1) || q_f !== 8'hA1 || rempty_f !== 1'b0 || rvalid_f !== 1'b1) begin
            errors++;
            $display("FAIL fill_%0d: got count=%0d q=%0h rempty=%b rvalid=%b want %0d/a1/0/1",
                     i, count_f, q_f, rempty_f, rvalid_f, i + 1);
         end
         checks++;
         if (wafull_f !== (i >= 1) || wfull_f !== (i == 3) || raempty_f !== (i == 0)) begin
            errors++;
            $display("FAIL fill_flags_%0d: got wafull=%b wfull=%b raempty=%b want %b/%b/%b",
                     i, wafull_f, wfull_f, raempty_f, i >= 1, i == 3, i == 0);
         end
      end
      d_f = 8'hA5;
      tick();
      we_f = 1'b0;
      checks++;
      if (overflow_f !== 1'b1 || count_f !== 3'd4 || q_f !== 8'hA1) begin
         errors++;
         $display("FAIL fill_overflow: got ovf=%b count=%0d q=%0h want 1/4/a1", overflow_f, count_f, q_f);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q_f !== vals[i]) begin
            errors++;
            $display("FAIL drain_q_%0d: got %0h want %0h", i, q_f, vals[i]);
         end
         re_f = 1'b1;
         tick();
         re_f = 1'b0;
         checks++;
         if (count_f !== 3'(3 - i)) begin
            errors++;
            $display("FAIL drain_cnt_%0d: got %0d want %0d", i, count_f, 3 - i);
         end
      end
      checks++;
      if (rempty_f !== 1'b1 || rvalid_f !== 1'b0 || overflow_f !== 1'b1 || underflow_f !== 1'b0) begin
         errors++;
         $display("FAIL drain_end: got rempty=%b rvalid=%b ovf=%b udf=%b want 1/0/1/0",
                  rempty_f, rvalid_f, overflow_f, underflow_f);
      end
   endtask

   task automatic test_reg_read();
      we_r = 1'b1; d_r = 8'h55;
      tick();
      we_r = 1'b0;
      checks++;
      if (count_r !== 3'd1 || rvalid_r !== 1'b0) begin
         errors++;
         $display("FAIL reg_wr: got count=%0d rvalid=%b want 1/0", count_r, rvalid_r);
      end
      re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (rvalid_r !== 1'b1 || q_r !== 8'h55 || rempty_r !== 1'b1) begin
         errors++;
         $display("FAIL reg_rd: got rvalid=%b q=%0h rempty=%b want 1/55/1", rvalid_r, q_r, rempty_r);
      end
      tick();
      checks++;
      if (rvalid_r !== 1'b0 || q_r !== 8'h55) begin
         errors++;
         $display("FAIL reg_hold: got rvalid=%b q=%0h want 0/55", rvalid_r, q_r);
      end
      re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (underflow_r !== 1'b1 || rvalid_r !== 1'b0 || count_r !== 3'd0) begin
         errors++;
         $display("FAIL reg_underflow: got udf=%b rvalid=%b count=%0d want 1/0/0",
                  underflow_r, rvalid_r, count_r);
      end
   endtask

   task automatic test_simul();
      flush_f = 1'b1;
      tick();
      flush_f = 1'b0;
      checks++;
      if (overflow_f !== 1'b0 || count_f !== 3'd0) begin
         errors++;
         $display("FAIL simul_flush: got ovf=%b count=%0d want 0/0", overflow_f, count_f);
      end
      for (int i = 0; i < 4; i++) begin
         we_f = 1'b1; d_f = 8'(8'hB0 + i);
         tick();
      end
      re_f = 1'b1; d_f = 8'hBF;
      tick();
      we_f = 1'b0; re_f = 1'b0;
      checks++;
      if (count_f !== 3'd3 || overflow_f !== 1'b1 || q_f !== 8'hB1 || underflow_f !== 1'b0) begin
         errors++;
         $display("FAIL simul_full: got count=%0d ovf=%b q=%0h udf=%b want 3/1/b1/0",
                  count_f, overflow_f, q_f, underflow_f);
      end
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (q_f !== 8'(8'hB0 + i)) begin
            errors++;
            $display("FAIL simul_drain_%0d: got %0h want %0h", i, q_f, 8'hB0 + i);
         end
         re_f = 1'b1;
         tick();
         re_f = 1'b0;
      end
      checks++;
      if (rempty_f !== 1'b1) begin
         errors++;
         $display("FAIL simul_empty: got rempty=%b want 1", rempty_f);
      end
      we_f = 1'b1; re_f = 1'b1; d_f = 8'hC0;
      tick();
      we_f = 1'b0; re_f = 1'b0;
      checks++;
      if (count_f !== 3'd1 || underflow_f !== 1'b1 || q_f !== 8'hC0 || rempty_f !== 1'b0) begin
         errors++;
         $display("FAIL simul_empty_wr: got count=%0d udf=%b q=%0h rempty=%b want 1/1/c0/0",
                  count_f, underflow_f, q_f, rempty_f);
      end
   endtask

   task automatic test_back_to_back();
      flush_f = 1'b1; flush_r = 1'b1;
      tick();
      flush_f = 1'b0; flush_r = 1'b0;
      for (int i = 0; i < 2; i++) begin
         we_f = 1'b1; we_r = 1'b1; d_f = 8'(i); d_r = 8'(i);
         tick();
      end
      for (int k = 0; k < 12; k++) begin
         we_f = 1'b1; we_r = 1'b1; re_f = 1'b1; re_r = 1'b1;
         d_f = 8'(k + 2); d_r = 8'(k + 2);
         tick();
         checks++;
         if (count_f !== 3'd2 || q_f !== 8'(k + 1)) begin
            errors++;
            $display("FAIL wrap_f_%0d: got count=%0d q=%0h want 2/%0h", k, count_f, q_f, k + 1);
         end
         checks++;
         if (count_r !== 3'd2 || q_r !== 8'(k) || rvalid_r !== 1'b1) begin
            errors++;
            $display("FAIL wrap_r_%0d: got count=%0d q=%0h rvalid=%b want 2/%0h/1",
                     k, count_r, q_r, rvalid_r, k);
         end
      end
      we_f = 1'b0; we_r = 1'b0; re_f = 1'b0; re_r = 1'b0;
   endtask

   task automatic test_flush();
      flush_r = 1'b1;
      tick();
      flush_r = 1'b0;
      for (int i = 0; i < 5; i++) begin
         we_r = 1'b1; d_r = 8'(8'hD0 + i);
         tick();
      end
      we_r = 1'b0; re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (count_r !== 3'd3 || overflow_r !== 1'b1 || rvalid_r !== 1'b1 || q_r !== 8'hD0) begin
         errors++;
         $display("FAIL flush_setup: got count=%0d ovf=%b rvalid=%b q=%0h want 3/1/1/d0",
                  count_r, overflow_r, rvalid_r, q_r);
      end
      flush_r = 1'b1; we_r = 1'b1; re_r = 1'b1; d_r = 8'hEE;
      tick();
      flush_r = 1'b0; we_r = 1'b0; re_r = 1'b0;
      checks++;
      if ({wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r} !== 7'b0011000) begin
         errors++;
         $display("FAIL flush_flags: got %b want 0011000",
                  {wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r});
      end
      checks++;
      if (count_r !== 3'd0 || q_r !== 8'hD0) begin
         errors++;
         $display("FAIL flush_cnt_q: got count=%0d q=%0h want 0/d0", count_r, q_r);
      end
      we_r = 1'b1; d_r = 8'h77;
      tick();
      we_r = 1'b0; re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (rvalid_r !== 1'b1 || q_r !== 8'h77 || count_r !== 3'd0) begin
         errors++;
         $display("FAIL flush_after: got rvalid=%b q=%0h count=%0d want 1/77/0", rvalid_r, q_r, count_r);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         we_r = 1'b1; d_r = 8'(8'h11 * (i + 1));
         tick();
      end
      we_r = 1'b0; re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (count_r !== 3'd2 || rvalid_r !== 1'b1 || q_r !== 8'h11) begin
         errors++;
         $display("FAIL mrst_setup: got count=%0d rvalid=%b q=%0h want 2/1/11", count_r, rvalid_r, q_r);
      end
      reset_r = 1'b1; we_r = 1'b1; re_r = 1'b1; d_r = 8'h99;
      tick();
      reset_r = 1'b0; we_r = 1'b0; re_r = 1'b0;
      checks++;
      if ({wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r} !== 7'b0011000
          || count_r !== 3'd0 || q_r !== 8'h00) begin
         errors++;
         $display("FAIL mrst_state: got flags=%b count=%0d q=%0h want 0011000/0/0",
                  {wfull_r, wafull_r, rempty_r, raempty_r, rvalid_r, overflow_r, underflow_r}, count_r, q_r);
      end
      we_r = 1'b1; d_r = 8'h44;
      tick();
      we_r = 1'b0;
      checks++;
      if (count_r !== 3'd1) begin
         errors++;
         $display("FAIL mrst_write: got count=%0d want 1", count_r);
      end
      re_r = 1'b1;
      tick();
      re_r = 1'b0;
      checks++;
      if (rvalid_r !== 1'b1 || q_r !== 8'h44) begin
         errors++;
         $display("FAIL mrst_read: got rvalid=%b q=%0h want 1/44", rvalid_r, q_r);
      end
   endtask

   initial begin
      reset_f = 1'b0; flush_f = 1'b0; we_f = 1'b0; re_f = 1'b0; d_f = 8'h00;
      reset_r = 1'b0; flush_r = 1'b0; we_r = 1'b0; re_r = 1'b0; d_r = 8'h00;
      test_reset();
      test_fill();
      test_reg_read();
      test_simul();
      test_back_to_back();
      test_flush();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfifo.md
Name: sfifo

Overview:
- Single-clock synchronous FIFO.
- Parametrised successor to the team's async FIFO wrapper, for paths where producer and consumer share one clock (AXI channel buffering, read-data reordering).
- Adds the following over the async wrapper:
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - almost-empty threshold
  - synchronous flush
  - sticky overflow/underflow error flags
  - exact occupancy count

Parameters:
AW, 4, log2(depth); capacity DEPTH=2**AW entries, AW>=1
DW, 32, data width, >=1
AFN, 2**AW-2, almost-full threshold: wafull when count>=AFN, range 1..DEPTH
AEN, 1, almost-empty threshold: raempty when count<=AEN, range 0..DEPTH-1
FWFT, 1, 1=first-word-fall-through, 0=registered read with 1-cycle latency

Ports:
clk      input   1       clock, all logic on rising edge
reset    input   1       synchronous active-high reset
flush    input   1       synchronous discard of all contents
we       input   1       write request
d        input   DW      write data
wfull    output  1       full: count==DEPTH
wafull   output  1       almost full
re       input   1       read request / pop
q        output  DW      read data
rvalid   output  1       q valid (FWFT: ==~rempty; standard: 1-cycle pulse)
rempty   output  1       empty: count==0
raempty  output  1       almost empty
count    output  AW+1    occupancy, 0..DEPTH
overflow output  1       sticky: write attempted while full
underflow output 1       sticky: read attempted while empty

Behaviour:
- Reset (reset=1 at a clk edge):
  - Pointers and count set to 0.
  - Outputs: wfull=0, wafull=0, rempty=1, raempty=1, rvalid=0, q=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset has priority over flush, we and re.
- Acceptance:
  - Write accepted (wt) iff we & ~wfull.
  - Read accepted (rd) iff re & ~rempty.
  - Flags are evaluated from the registered state at the start of the cycle.
  - A read in the same cycle does not free space for a write to a full FIFO.
  - A write in the same cycle does not satisfy a read from an empty FIFO.
- Count:
  - Next count = count + wt - rd; wt&rd leaves count unchanged.
  - Never exceeds DEPTH, never goes below 0.
- Status flags:
  - wfull, wafull, rempty and raempty are decoded only from the count register.
  - No combinational path from we/re/d to any output.
- Pointers:
  - Write and read pointers are AW bits wide and wrap modulo DEPTH without a bubble.
  - Entry order is strictly preserved across wrap.
- FWFT=1 mode:
  - Head entry is presented on q whenever rempty=0; rvalid=~rempty.
  - A write to an empty FIFO makes rempty=0, with q=d, on the cycle after the write edge (1-cycle write-to-visible latency).
  - rd pops the head; the next entry is on q the following cycle, or rempty=1 if none remain.
  - q is don't-care while rempty=1.
- FWFT=0 mode:
  - rd at edge N drives q=head entry and rvalid=1 after edge N (pulse, one cycle per accepted read).
  - Back-to-back reads give back-to-back rvalid.
  - q holds its last value when rvalid=0.
- Flush (flush=1, reset=0):
  - Next cycle: count=0, pointers=0, rempty=1, raempty=1, wfull=0, wafull=0, rvalid=0, overflow=0, underflow=0.
  - we/re in the flush cycle are ignored: no write, no pop, no error flag set.
  - In FWFT=0 mode q holds its value.
- Error flags:
  - overflow sets on we&wfull; underflow sets on re&rempty.
  - Once set, they stay set until reset or flush.
  - Rejected operations do not alter memory, pointers or count.
- Storage: register or inferred RAM, DEPTH x DW.
- Capacity is exactly DEPTH in both modes; the FWFT output stage counts toward occupancy.

Test Plan:
1. AW=2, FWFT=1: write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles, no reads.
   - Required: rempty=0 one cycle after first write, q=0xA1.
   - count 1,2,3,4; wafull at count>=2; wfull at 4.
   - Fifth write with we=1 -> overflow=1, count stays 4, contents unchanged.
2. FWFT=0, one entry 0x55 present: re pulse -> rvalid=1 with q=0x55 on the next cycle only, then rempty=1.
   - Further re -> underflow=1, rvalid stays 0.
3. Full FIFO, we&re same cycle -> read accepted, write rejected, count=DEPTH-1, overflow=1.
   - Empty FIFO, we&re same cycle -> write accepted, read rejected, count=1, underflow=1.
4. Continuous we&re at half occupancy for 3*DEPTH cycles with incrementing data -> count constant, output order exactly matches input order across pointer wrap-around.
5. Flush with count=3, overflow=1, and we=1, re=1 asserted in the same cycle -> next cycle count=0, rempty=1, overflow=0, rvalid=0.
   - A subsequent single write is read back correctly.
6. Assert reset mid-stream (count=2, rvalid=1 in FWFT=0) -> next cycle all outputs at reset values, q=0.
   - Writes are accepted on the first cycle after reset deasserts.
